// File: rtl/mbscore_pic.sv
// Programmable interrupt controller: edge-captured requests, per-source enables,
// fixed lowest-index priority, and a claim/EOI handshake over the CPU bus.
module mbscore_pic #(
    parameter int                    N_SRC      = 8,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h0000_FF00
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      irq_src,
    input  logic                  cpu_int_dis,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_re,
    input  logic                  bus_we,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_oe,
    output logic                  int_vec
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_CLAIMED = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [N_SRC-1:0] irq_prev_reg, pending_reg, pending_next, enable_reg, enable_next;
    logic [N_SRC-1:0] active, rise, w1c_mask, claim_mask;
    logic [4:0]       insvc_id_reg, insvc_id_next, winner;
    logic             int_vec_reg, int_vec_next, re_prev_reg;
    logic             hit, wr_hit, claim_fire, eoi;
    logic [1:0]       sel;

    assign hit    = (bus_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign sel    = bus_addr[3:2];
    assign wr_hit = bus_we & hit;
    assign active = pending_reg & enable_reg;

    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) winner = 5'(i);
        end
    end

    // A held read strobe claims only once: the side effect needs a fresh bus_re.
    assign claim_fire = bus_re & ~bus_we & ~re_prev_reg & hit & (sel == 2'd2)
                      & (state_reg == ST_REQ) & (active != '0);
    assign eoi        = wr_hit & (sel == 2'd2) & (state_reg == ST_CLAIMED);
    assign w1c_mask   = (wr_hit && sel == 2'd0) ? bus_wdata[N_SRC-1:0] : '0;

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign rise[gi]       = irq_src[gi] & ~irq_prev_reg[gi];
            assign claim_mask[gi] = claim_fire && (winner == 5'(gi));
        end
    endgenerate

    // New edges win over any clear arriving in the same cycle.
    assign pending_next  = (pending_reg & ~w1c_mask & ~claim_mask) | rise;
    assign enable_next   = (wr_hit && sel == 2'd1) ? bus_wdata[N_SRC-1:0] : enable_reg;
    assign insvc_id_next = claim_fire ? winner : insvc_id_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            irq_prev_reg <= '0;
            pending_reg  <= '0;
            enable_reg   <= '0;
            insvc_id_reg <= '0;
            int_vec_reg  <= 1'b0;
            re_prev_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            irq_prev_reg <= irq_src;
            pending_reg  <= pending_next;
            enable_reg   <= enable_next;
            insvc_id_reg <= insvc_id_next;
            int_vec_reg  <= int_vec_next;
            re_prev_reg  <= bus_re;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (active != '0 && !cpu_int_dis) state_next = ST_REQ;
            ST_REQ:     if (claim_fire) state_next = ST_CLAIMED;
                        else if (active == '0) state_next = ST_IDLE;
            ST_CLAIMED: if (eoi) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // The pulse marks only the IDLE->REQ entry, so it lasts exactly one cycle.
    always_comb begin
        int_vec_next = (state_reg == ST_IDLE) && (state_next == ST_REQ);
    end

    assign int_vec = int_vec_reg;

    always_comb begin
        bus_rdata = '0;
        if (bus_re && hit) begin
            case (sel)
                2'd0: bus_rdata = DATA_WIDTH'(pending_reg);
                2'd1: bus_rdata = DATA_WIDTH'(enable_reg);
                2'd2: if (state_reg == ST_REQ && active != '0)
                          bus_rdata = DATA_WIDTH'({1'b1, 26'b0, winner});
                default: bus_rdata = DATA_WIDTH'({22'b0, state_reg, 3'b0, insvc_id_reg});
            endcase
        end
    end

    assign bus_oe = bus_re & hit & ~bus_we;

    logic unused_bits;
    assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata[DATA_WIDTH-1:N_SRC]};

endmodule
